// File: rtl/riscv_mc_controller_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, select
// codes, ALU operation codes, state encoding and the decode-stage dispatch.
package riscv_mc_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC     = 2'd0;
    localparam logic [1:0] SRCA_OLDPC  = 2'd1;
    localparam logic [1:0] SRCA_RS1    = 2'd2;
    localparam logic [1:0] SRCB_RS2    = 2'd0;
    localparam logic [1:0] SRCB_IMM    = 2'd1;
    localparam logic [1:0] SRCB_FOUR   = 2'd2;
    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MEMDATA = 2'd1;
    localparam logic [1:0] RES_ALURES  = 2'd2;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_src_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_XOR   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_AND   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_AUIPC,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR_A,
        S_JALR_B,
        S_TRAP
    } state_e;

    // Dispatch out of DECODE; branches with funct3 2/3 have no encoding and trap here.
    function automatic state_e decode_next(input logic [6:0] opcode, input logic [2:0] funct3);
        state_e nxt;
        case (opcode)
            OP_LOAD, OP_STORE: nxt = S_MEMADR;
            OP_R:              nxt = S_EXECR;
            OP_I:              nxt = S_EXECI;
            OP_BRANCH:         nxt = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
            OP_JAL:            nxt = S_JAL;
            OP_JALR:           nxt = S_JALR_A;
            OP_LUI:            nxt = S_LUI;
            OP_AUIPC:          nxt = S_AUIPC;
            default:           nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/riscv_mc_controller_alu_dec.sv
// ALU operation decode from funct3/funct7[5]. For immediate-form instructions
// funct7[5] only distinguishes SRAI from SRLI, so ADDI never turns into SUB.
module riscv_mc_controller_alu_dec
    import riscv_mc_controller_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_is_imm,
    output logic [3:0] o_alu_control
);

    // Funct3 table with the two funct7[5] alternates.
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_funct3)
            3'd0: o_alu_control = (i_funct7b5 && !i_is_imm) ? ALU_SUB : ALU_ADD;
            3'd1: o_alu_control = ALU_SLL;
            3'd2: o_alu_control = ALU_SLT;
            3'd3: o_alu_control = ALU_SLTU;
            3'd4: o_alu_control = ALU_XOR;
            3'd5: o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
            3'd6: o_alu_control = ALU_OR;
            3'd7: o_alu_control = ALU_AND;
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control FSM. Sequences the shared datapath per state,
// owns the memory request handshake and raises sticky Illegal / BusErr flags.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  FETCH     | read instr at PC, PC+4 -> PC, load IR/OldPC on MemReady
//  DECODE    | OldPC + Imm -> ALUOut (branch/jump target), dispatch
//  MEMADR    | rs1 + Imm -> ALUOut (load/store address)
//  MEMREAD   | read at ALUOut until MemReady
//  MEMWB     | MemData -> rd
//  MEMWRITE  | write at ALUOut until MemReady
//  EXECR     | rs1 op rs2 -> ALUOut
//  EXECI     | rs1 op Imm -> ALUOut
//  LUI       | U-imm -> ALUOut
//  AUIPC     | OldPC + U-imm -> ALUOut
//  ALUWB     | ALUOut -> rd
//  BRANCH    | compare rs1/rs2, PC <- target when taken
//  JAL       | OldPC + 4 -> rd, PC <- ALUOut
//  JALR_A    | rs1 + Imm -> ALUOut
//  JALR_B    | OldPC + 4 -> rd, PC <- ALUOut
//  TRAP      | halted until reset
module riscv_mc_controller
    import riscv_mc_controller_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_cmp_lt,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_w,
    output logic       o_adr_src,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_reg_w,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_result_src,
    output logic [2:0] o_imm_src,
    output logic [3:0] o_alu_control,
    output logic       o_instr_done,
    output logic       o_illegal,
    output logic       o_bus_err
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST =
        (WAIT_LIMIT == 0) ? '0 : CNT_W'(WAIT_LIMIT - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_illegal;
    logic             r_bus_err;

    state_e     w_decode_next;
    logic       w_mem_state;
    logic       w_timeout;
    logic       w_is_imm;
    logic       w_taken;
    logic [3:0] w_alu_dec;

    assign w_decode_next = decode_next(i_opcode, i_funct3);
    assign w_mem_state   = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign w_timeout     = (WAIT_LIMIT != 0) && w_mem_state && !i_mem_ready && (r_wait_cnt == LP_CNT_LAST);
    assign w_is_imm      = (r_state == S_EXECI);
    // funct3[2] picks the less-than compare over equality; funct3[0] inverts the sense.
    assign w_taken       = i_funct3[0] ^ (i_funct3[2] ? i_cmp_lt : i_zero);

    riscv_mc_controller_alu_dec u_alu_dec (
        .i_funct3      (i_funct3),
        .i_funct7b5    (i_funct7b5),
        .i_is_imm      (w_is_imm),
        .o_alu_control (w_alu_dec)
    );

    // State sequencing, memory wait counter and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            // Leaving a request state always happens on MemReady, so the count is
            // already zero when the next request state is entered.
            if (w_mem_state && !i_mem_ready) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end

            if (w_timeout) begin
                r_bus_err <= 1'b1;
                r_state   <= S_TRAP;
            end else begin
                case (r_state)
                    S_FETCH:    if (i_mem_ready) r_state <= S_DECODE;
                    S_DECODE: begin
                        r_state <= w_decode_next;
                        if (w_decode_next == S_TRAP) r_illegal <= 1'b1;
                    end
                    S_MEMADR:   r_state <= (i_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                    S_MEMREAD:  if (i_mem_ready) r_state <= S_MEMWB;
                    S_MEMWRITE: if (i_mem_ready) r_state <= S_FETCH;
                    S_EXECR, S_EXECI, S_LUI, S_AUIPC: r_state <= S_ALUWB;
                    S_JALR_A:   r_state <= S_JALR_B;
                    S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR_B: r_state <= S_FETCH;
                    S_TRAP:     r_state <= S_TRAP;
                    default:    r_state <= S_TRAP;
                endcase
            end
        end
    end

    // Output decode from the state register; reset blanks every output immediately.
    always_comb begin
        o_mem_req     = 1'b0;
        o_mem_w       = 1'b0;
        o_adr_src     = 1'b0;
        o_ir_write    = 1'b0;
        o_pc_write    = 1'b0;
        o_reg_w       = 1'b0;
        o_alu_src_a   = SRCA_PC;
        o_alu_src_b   = SRCB_RS2;
        o_result_src  = RES_ALUOUT;
        o_imm_src     = IMM_R;
        o_alu_control = ALU_ADD;
        o_instr_done  = 1'b0;
        o_illegal     = 1'b0;
        o_bus_err     = 1'b0;
        if (!i_reset) begin
            o_illegal = r_illegal;
            o_bus_err = r_bus_err;
            case (r_state)
                S_FETCH: begin
                    o_mem_req    = 1'b1;
                    o_alu_src_b  = SRCB_FOUR;
                    o_result_src = RES_ALURES;
                    o_ir_write   = i_mem_ready;
                    o_pc_write   = i_mem_ready;
                end
                S_DECODE: begin
                    o_alu_src_a = SRCA_OLDPC;
                    o_alu_src_b = SRCB_IMM;
                    if (i_opcode == OP_BRANCH) begin
                        o_imm_src = IMM_B;
                    end else if (i_opcode == OP_JAL) begin
                        o_imm_src = IMM_J;
                    end else begin
                        o_imm_src = IMM_I;
                    end
                end
                S_MEMADR: begin
                    o_alu_src_a = SRCA_RS1;
                    o_alu_src_b = SRCB_IMM;
                    o_imm_src   = (i_opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    o_mem_req = 1'b1;
                    o_adr_src = 1'b1;
                end
                S_MEMWB: begin
                    o_reg_w      = 1'b1;
                    o_result_src = RES_MEMDATA;
                    o_instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    o_mem_req    = 1'b1;
                    o_mem_w      = 1'b1;
                    o_adr_src    = 1'b1;
                    o_instr_done = i_mem_ready;
                end
                S_EXECR: begin
                    o_alu_src_a   = SRCA_RS1;
                    o_alu_src_b   = SRCB_RS2;
                    o_alu_control = w_alu_dec;
                end
                S_EXECI: begin
                    o_alu_src_a   = SRCA_RS1;
                    o_alu_src_b   = SRCB_IMM;
                    o_imm_src     = IMM_I;
                    o_alu_control = w_alu_dec;
                end
                S_LUI: begin
                    o_alu_src_b   = SRCB_IMM;
                    o_imm_src     = IMM_U;
                    o_alu_control = ALU_PASSB;
                end
                S_AUIPC: begin
                    o_alu_src_a = SRCA_OLDPC;
                    o_alu_src_b = SRCB_IMM;
                    o_imm_src   = IMM_U;
                end
                S_ALUWB: begin
                    o_reg_w      = 1'b1;
                    o_instr_done = 1'b1;
                end
                S_BRANCH: begin
                    o_alu_src_a  = SRCA_RS1;
                    o_alu_src_b  = SRCB_RS2;
                    o_imm_src    = IMM_B;
                    o_pc_write   = w_taken;
                    o_instr_done = 1'b1;
                    if (!i_funct3[2]) begin
                        o_alu_control = ALU_SUB;
                    end else if (!i_funct3[1]) begin
                        o_alu_control = ALU_SLT;
                    end else begin
                        o_alu_control = ALU_SLTU;
                    end
                end
                S_JALR_A: begin
                    o_alu_src_a = SRCA_RS1;
                    o_alu_src_b = SRCB_IMM;
                    o_imm_src   = IMM_I;
                end
                // ALUOut still holds the jump target; the ALU result (OldPC+4) is the link.
                S_JAL, S_JALR_B: begin
                    o_alu_src_a  = SRCA_OLDPC;
                    o_alu_src_b  = SRCB_FOUR;
                    o_result_src = RES_ALURES;
                    o_reg_w      = 1'b1;
                    o_pc_write   = 1'b1;
                    o_instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Bench for the multi-cycle controller: every instruction is expanded into a
// cycle-by-cycle list of expected outputs, which is then replayed against the DUT.
module tb_riscv_mc_controller;

    localparam bit [8:0] M_REQ  = 9'h100;
    localparam bit [8:0] M_W    = 9'h080;
    localparam bit [8:0] M_ADR  = 9'h040;
    localparam bit [8:0] M_REGW = 9'h020;
    localparam bit [8:0] M_PCW  = 9'h010;
    localparam bit [8:0] M_IRW  = 9'h008;
    localparam bit [8:0] M_DONE = 9'h004;
    localparam bit [8:0] M_ILL  = 9'h002;
    localparam bit [8:0] M_BERR = 9'h001;

    localparam int C_R = 0, C_I = 1, C_LUI = 2, C_AUIPC = 3, C_LOAD = 4,
                   C_STORE = 5, C_BR = 6, C_JAL = 7, C_JALR = 8;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [6:0] i_opcode = '0;
    logic [2:0] i_funct3 = '0;
    logic       i_funct7b5 = 1'b0;
    logic       i_zero = 1'b0;
    logic       i_cmp_lt = 1'b0;
    logic       i_mem_ready = 1'b0;
    logic       o_mem_req, o_mem_w, o_adr_src, o_ir_write, o_pc_write, o_reg_w;
    logic [1:0] o_alu_src_a, o_alu_src_b, o_result_src;
    logic [2:0] o_imm_src;
    logic [3:0] o_alu_control;
    logic       o_instr_done, o_illegal, o_bus_err;

    typedef struct {
        bit       rst;
        bit       rdy;
        bit [8:0] ctl;
        int       aluc;
        int       rsrc;
    } cyc_t;

    cyc_t     plan[$];
    int       n_checks = 0;
    int       n_errors = 0;
    int       n_cycle  = 0;
    bit [6:0] opcodes[9];

    always #5 clk = ~clk;

    riscv_mc_controller #(.WAIT_LIMIT(16), .CNT_W(5)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_opcode      (i_opcode),
        .i_funct3      (i_funct3),
        .i_funct7b5    (i_funct7b5),
        .i_zero        (i_zero),
        .i_cmp_lt      (i_cmp_lt),
        .i_mem_ready   (i_mem_ready),
        .o_mem_req     (o_mem_req),
        .o_mem_w       (o_mem_w),
        .o_adr_src     (o_adr_src),
        .o_ir_write    (o_ir_write),
        .o_pc_write    (o_pc_write),
        .o_reg_w       (o_reg_w),
        .o_alu_src_a   (o_alu_src_a),
        .o_alu_src_b   (o_alu_src_b),
        .o_result_src  (o_result_src),
        .o_imm_src     (o_imm_src),
        .o_alu_control (o_alu_control),
        .o_instr_done  (o_instr_done),
        .o_illegal     (o_illegal),
        .o_bus_err     (o_bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, n_cycle, act, exp);
        end
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // Reference ALU operation for register/immediate arithmetic.
    function automatic int exp_alu(input bit [2:0] f3, input bit f7, input bit is_imm);
        int tab[8];
        tab = '{0, 5, 8, 9, 2, 6, 3, 4};
        if (f3 == 3'd0 && f7 && !is_imm) return 1;
        if (f3 == 3'd5 && f7) return 7;
        return tab[f3];
    endfunction

    function automatic bit exp_taken(input bit [2:0] f3, input bit z, input bit lt);
        case (f3)
            3'd0:       return z;
            3'd1:       return !z;
            3'd4, 3'd6: return lt;
            default:    return !lt;
        endcase
    endfunction

    task automatic push(input bit rdy, input bit [8:0] ctl, input int aluc, input int rsrc);
        plan.push_back('{1'b0, rdy, ctl, aluc, rsrc});
    endtask

    task automatic push_rst();
        plan.push_back('{1'b1, rb(), 9'h000, 0, 0});
    endtask

    task automatic push_fetch(input int nw);
        for (int i = 0; i < nw; i++) push(1'b0, M_REQ, 0, 2);
        push(1'b1, M_REQ | M_PCW | M_IRW, 0, 2);
    endtask

    // Replay the plan: drive just after the rising edge, sample on the falling edge.
    task automatic run_plan();
        logic [8:0] act;
        foreach (plan[k]) begin
            i_reset     = plan[k].rst;
            i_mem_ready = plan[k].rdy;
            @(negedge clk);
            act = {o_mem_req, o_mem_w, o_adr_src, o_reg_w, o_pc_write,
                   o_ir_write, o_instr_done, o_illegal, o_bus_err};
            chk("ctl", 32'(act), 32'(plan[k].ctl));
            chk("alu_control", 32'(o_alu_control), 32'(plan[k].aluc));
            chk("result_src", 32'(o_result_src), 32'(plan[k].rsrc));
            @(posedge clk);
            #1;
            n_cycle++;
        end
        plan.delete();
    endtask

    task automatic do_instr(input int cls, input bit [2:0] f3, input bit f7,
                            input int fw, input int mw, input bit z, input bit lt);
        i_opcode   = opcodes[cls];
        i_funct3   = f3;
        i_funct7b5 = f7;
        i_zero     = z;
        i_cmp_lt   = lt;
        push_fetch(fw);
        push(rb(), 9'h000, 0, 0);
        case (cls)
            C_R: begin
                push(rb(), 9'h000, exp_alu(f3, f7, 1'b0), 0);
                push(rb(), M_REGW | M_DONE, 0, 0);
            end
            C_I: begin
                push(rb(), 9'h000, exp_alu(f3, f7, 1'b1), 0);
                push(rb(), M_REGW | M_DONE, 0, 0);
            end
            C_LUI: begin
                push(rb(), 9'h000, 10, 0);
                push(rb(), M_REGW | M_DONE, 0, 0);
            end
            C_AUIPC: begin
                push(rb(), 9'h000, 0, 0);
                push(rb(), M_REGW | M_DONE, 0, 0);
            end
            C_LOAD: begin
                push(rb(), 9'h000, 0, 0);
                for (int i = 0; i < mw; i++) push(1'b0, M_REQ | M_ADR, 0, 0);
                push(1'b1, M_REQ | M_ADR, 0, 0);
                push(rb(), M_REGW | M_DONE, 0, 1);
            end
            C_STORE: begin
                push(rb(), 9'h000, 0, 0);
                for (int i = 0; i < mw; i++) push(1'b0, M_REQ | M_W | M_ADR, 0, 0);
                push(1'b1, M_REQ | M_W | M_ADR | M_DONE, 0, 0);
            end
            C_BR: begin
                int alu;
                if (f3 == 3'd0 || f3 == 3'd1) alu = 1;
                else if (f3 == 3'd4 || f3 == 3'd5) alu = 8;
                else alu = 9;
                push(rb(), M_DONE | (exp_taken(f3, z, lt) ? M_PCW : 9'h000), alu, 0);
            end
            C_JAL: begin
                push(rb(), M_REGW | M_PCW | M_DONE, 0, 2);
            end
            default: begin
                push(rb(), 9'h000, 0, 0);
                push(rb(), M_REGW | M_PCW | M_DONE, 0, 2);
            end
        endcase
        run_plan();
    endtask

    initial begin
        bit [2:0] br_f3[6];
        opcodes = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                    7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
        br_f3   = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        // Reset: every output held low.
        push_rst();
        push_rst();
        run_plan();

        // ADD x3,x1,x2 (0x002081B3), no waits.
        do_instr(C_R, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);
        // SUB and SRAI / ADDI with funct7[5] set.
        do_instr(C_R, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0);
        do_instr(C_I, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0);
        do_instr(C_I, 3'd5, 1'b1, 1, 0, 1'b0, 1'b0);
        // LW with MemReady low for two cycles in MEMREAD.
        do_instr(C_LOAD, 3'd2, 1'b0, 0, 2, 1'b0, 1'b0);
        // BEQ taken, BNE not taken, BLTU taken.
        do_instr(C_BR, 3'd0, 1'b0, 0, 0, 1'b1, 1'b0);
        do_instr(C_BR, 3'd1, 1'b0, 0, 0, 1'b1, 1'b0);
        do_instr(C_BR, 3'd6, 1'b0, 0, 0, 1'b0, 1'b1);

        // Random instruction mix with random memory waits.
        for (int n = 0; n < 300; n++) begin
            int       cls;
            bit [2:0] f3;
            cls = int'($urandom_range(0, 8));
            f3  = (cls == C_BR) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            do_instr(cls, f3, rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb(), rb());
        end

        // Unsupported opcode: trap with Illegal, no enables, until reset.
        i_opcode = 7'h7F;
        push_fetch(0);
        push(rb(), 9'h000, 0, 0);
        for (int i = 0; i < 20; i++) push(rb(), M_ILL, 0, 0);
        push_rst();
        run_plan();
        do_instr(C_JAL, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);

        // Branch with funct3 = 2 has no encoding.
        i_opcode = 7'b1100011;
        i_funct3 = 3'd2;
        push_fetch(0);
        push(rb(), 9'h000, 0, 0);
        for (int i = 0; i < 4; i++) push(rb(), M_ILL, 0, 0);
        push_rst();
        run_plan();

        // Store that is never acknowledged: BusErr 16 cycles after MEMWRITE entry.
        i_opcode = 7'b0100011;
        i_funct3 = 3'd2;
        push_fetch(0);
        push(rb(), 9'h000, 0, 0);
        push(rb(), 9'h000, 0, 0);
        for (int i = 0; i < 16; i++) push(1'b0, M_REQ | M_W | M_ADR, 0, 0);
        for (int i = 0; i < 5; i++) push(rb(), M_BERR, 0, 0);
        push_rst();
        run_plan();

        // Fetch that is never acknowledged also times out.
        push_fetch(16);
        plan.delete();
        for (int i = 0; i < 16; i++) push(1'b0, M_REQ, 0, 2);
        push(1'b0, M_BERR, 0, 0);
        push_rst();
        run_plan();

        // Reset in the middle of MEMREAD: outputs drop, fetch restarts next cycle.
        i_opcode = 7'b0000011;
        push_fetch(0);
        push(rb(), 9'h000, 0, 0);
        push(rb(), 9'h000, 0, 0);
        push(1'b0, M_REQ | M_ADR, 0, 0);
        plan.push_back('{1'b1, 1'b1, 9'h000, 0, 0});
        run_plan();
        do_instr(C_R, 3'd7, 1'b0, 0, 0, 1'b0, 1'b0);
        do_instr(C_STORE, 3'd2, 1'b0, 2, 3, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
